bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter: the reverse of the display-side binary-to-BCD path. It takes a packed NDIGITS-digit BCD value, such as a keyed-in or stored reaction-time limit in milliseconds, and produces the equivalent unsigned binary value. It uses reverse double-dabble, one bit per clock. It shares the start/ready/done_tick handshake of the existing binary-to-BCD converter, so controllers can drive either one the same way.

## Interface
- NDIGITS, 4, number of BCD digits (1..8)
- BW, derived localparam, ceil(log2(10^NDIGITS)) (14 for NDIGITS=4), binary result width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  conversion request; sampled only while ready=1
- bcd  in  4*NDIGITS  packed digits, digit 0 in bcd[3:0], most significant digit in the top nibble
- ready  out  1  high in IDLE; a start in this cycle is accepted
- done_tick  out  1  one-cycle pulse; result and err valid
- bin  out  BW  binary result, held until the next accepted start
- err  out  1  an input digit was >9; held with bin

## Operation
- **FSM states.** IDLE, OP, DONE.
- **IDLE.** ready=1.
  - On start=1, latch bcd into the shift register bcd_q, clear the accumulator bin_q (4*NDIGITS bits) and set n=4*NDIGITS-1.
  - If any digit in bcd is >9: set err=1, bin=0, go directly to DONE.
  - Otherwise: set err=0 and go to OP.
- **OP**, executed every cycle:
  - Shift the concatenation {bcd_q, bin_q} right by 1. bcd_q[0] enters bin_q MSB; bcd_q MSB becomes 0.
  - After the shift, subtract 3 from each digit of bcd_q that is ≥8.
  - If n==0, load bin = next bin_q[BW-1:0] and go to DONE; else n decrements by 1.
- **DONE.** done_tick=1 for exactly one cycle, then IDLE.
- **Ignored start.** start in OP or DONE is ignored; it is neither queued nor does it cause an error.
- **Held inputs.** bcd is sampled only on the accepting edge. Later changes to bcd do not affect the conversion in progress.
- **Result width.** The result fits in BW bits for every valid input. Accumulator bits above BW are always 0 and are discarded.

## Timing
- **Reset values.** ready=1, done_tick=0, bin=0, err=0, state IDLE.
- **Valid input.** start is accepted at edge E0.
  - OP occupies 4*NDIGITS cycles.
  - done_tick is high in the cycle after edge E(4*NDIGITS), i.e. 17 cycles after acceptance for NDIGITS=4.
  - ready returns to 1 the cycle after done_tick.
- **Invalid input.** done_tick is high in the cycle immediately after E0 (latency 1), with err=1 and bin=0.
- **Output stability.** bin and err change only on the edge that enters DONE. They hold stable through DONE and IDLE, including the next OP phase.
- **start held high.** A new conversion is accepted in the first IDLE cycle, so back-to-back period = 4*NDIGITS+2 cycles.
- **rst mid-operation.** rst in any state returns to the reset values on the next edge. The conversion in progress is aborted and no done_tick is produced.
- **done_tick vs outputs.** done_tick is decoded from state==DONE. It is coincident with valid bin/err and never asserted in two consecutive cycles.

## Structure
- **Shared package** (alongside the other display/timer types):
  - state enum (IDLE, OP, DONE)
  - function returning BW from NDIGITS
  - function checking digit validity
- **Module contents.** Single flat module, no sub-module: one state/datapath register block and one combinational next-state block. The per-digit ≥8 correction is a generate loop over NDIGITS.

## Test plan
- **Zero.** bcd=16'h0000, start pulse → done_tick 17 cycles later, bin=0, err=0.
- **Maximum.** bcd=16'h9999 → bin=14'd9999 (0x270F), err=0; ready low for cycles 1..17 after acceptance.
- **Typical value.** bcd=16'h1234 → bin=0x04D2. bcd changed to 16'h5678 during OP → result still 0x04D2. Then start with 16'h0100 → bin=100.
- **Invalid digit.** bcd=16'h12A4 → done_tick in the cycle after acceptance, err=1, bin=0. Next valid start clears err.
- **Busy start.** start re-pulsed during OP and during DONE → exactly one done_tick. start held high continuously → done_tick every 18 cycles.
- **Reset mid-operation.** rst asserted 5 cycles into OP → next cycle ready=1, bin=0, err=0, and no done_tick appears. A subsequent conversion of 16'h0042 gives bin=42.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared types and helpers for the BCD/binary conversion blocks.
// Holds the converter state encoding, result-width sizing and digit validation.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest width whose range covers every NDIGITS-digit decimal value.
  function automatic int calc_bw(input int ndig);
    longint p;
    int     b;
    p = 1;
    for (int i = 0; i < ndig; i++) p = p * 10;
    b = 0;
    for (int i = 0; i < 63; i++) begin
      if ((longint'(1) << b) < p) b = b + 1;
    end
    return b;
  endfunction

  // Up to 8 digits are supported, so callers pass the value zero-extended to 32 bits.
  function automatic logic bcd_all_valid(input logic [31:0] v, input int ndig);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig && v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Shares the start/ready/done_tick handshake with the binary-to-BCD converter.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int NDIGITS = 4,
  localparam int BW     = calc_bw(NDIGITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] bcd,
  output logic                 ready,
  output logic                 done_tick,
  output logic [BW-1:0]        bin,
  output logic                 err
);

  localparam int W  = 4 * NDIGITS;
  localparam int NW = $clog2(W);
  localparam logic [NW-1:0] N_LAST = NW'(W - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [NW-1:0]   n_q, n_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            err_q, err_d;

  logic [W-1:0]    bcd_sh, bcd_fix, acc_sh;

  // Shift {bcd_q, acc_q} right by one; the LSB of the BCD side feeds the accumulator MSB.
  assign bcd_sh = {1'b0, bcd_q[W-1:1]};
  assign acc_sh = {bcd_q[0], acc_q[W-1:1]};

  for (genvar g = 0; g < NDIGITS; g++) begin : g_fix
    assign bcd_fix[4*g +: 4] = (bcd_sh[4*g +: 4] >= 4'd8) ? (bcd_sh[4*g +: 4] - 4'd3)
                                                           : bcd_sh[4*g +: 4];
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    n_d     = n_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d = bcd;
          acc_d = '0;
          n_d   = N_LAST;
          if (!bcd_all_valid(32'(bcd), NDIGITS)) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_OP;
          end
        end
      end
      ST_OP: begin
        bcd_d = bcd_fix;
        acc_d = acc_sh;
        // Results are published only on entry to DONE so bin/err stay stable meanwhile.
        if (n_q == '0) begin
          bin_d   = acc_sh[BW-1:0];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          n_d = n_q - NW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    bcd_q <= bcd_d;
    acc_q <= acc_d;
    n_q   <= n_d;
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign bin       = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin (NDIGITS=4): vector table plus handshake corner sequences.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic        ready;
  logic        done_tick;
  logic [13:0] bin;
  logic        err;

  bcd2bin #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd       (bcd),
    .ready     (ready),
    .done_tick (done_tick),
    .bin       (bin),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          mon_en = 0;
  logic        prev_done = 1'b0;
  int          cyc = 0;
  logic [13:0] last_bin;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done_tick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && done_tick === 1'b1) begin
      if (prev_done === 1'b1) check("done_consecutive", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("bin", 32'(bin), 32'(mon_e.bin));
        check("err", 32'(err), 32'(mon_e.err));
      end
    end
    prev_done = done_tick;
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic run_conv(input logic [15:0] v, input logic [13:0] eb, input logic ee,
                          input int elat, input bit busy, input bit chg);
    int lat;
    bit fin, rdy_bad, stab_bad;
    wait_ready();
    bcd   = v;
    start = 1'b1;
    sbq.push_back('{bin: eb, err: ee});
    @(posedge clk); #1;
    if (!busy) start = 1'b0;
    if (chg) bcd = 16'h5678;
    lat = 1; fin = 0; rdy_bad = 0; stab_bad = 0;
    while (!fin && lat <= 40) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_bad = 1;
      if (done_tick === 1'b1) begin
        fin = 1;
      end else begin
        if (bin !== last_bin || err !== last_err) stab_bad = 1;
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(elat));
    check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
    if (elat > 1) check("hold_during_op", 32'(stab_bad), 32'd0);
    @(negedge clk);
    check("ready_after_done", 32'(ready), 32'd1);
    last_bin = eb;
    last_err = ee;
  endtask

  initial begin
    vec_t tbl[10];
    int   t[3];
    int   guard;
    tbl[0] = '{16'h0000, 14'd0,    1'b0};
    tbl[1] = '{16'h9999, 14'd9999, 1'b0};
    tbl[2] = '{16'h1234, 14'd1234, 1'b0};
    tbl[3] = '{16'h0100, 14'd100,  1'b0};
    tbl[4] = '{16'h12A4, 14'd0,    1'b1};
    tbl[5] = '{16'h0100, 14'd100,  1'b0};
    tbl[6] = '{16'h0001, 14'd1,    1'b0};
    tbl[7] = '{16'h8000, 14'd8000, 1'b0};
    tbl[8] = '{16'hF000, 14'd0,    1'b1};
    tbl[9] = '{16'h5678, 14'd5678, 1'b0};

    rst = 1'b1; start = 1'b0; bcd = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_bin = '0; last_err = 1'b0;
    mon_en = 1;

    for (int i = 0; i < 10; i++)
      run_conv(tbl[i].bcd, tbl[i].bin, tbl[i].err, tbl[i].err ? 1 : 17, 1'b0, 1'b0);

    // Input changes after acceptance must not disturb the conversion.
    run_conv(16'h1234, 14'd1234, 1'b0, 17, 1'b0, 1'b1);
    // start held through OP and DONE: only one conversion.
    run_conv(16'h0250, 14'd250, 1'b0, 17, 1'b1, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    check("busy_single_done", 32'(sbq.size()), 32'd0);

    // Continuous start: back-to-back conversions every 18 cycles.
    wait_ready();
    for (int k = 0; k < 3; k++) sbq.push_back('{bin: 14'd777, err: 1'b0});
    bcd = 16'h0777; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      @(negedge clk);
      while (done_tick !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (done_tick !== 1'b1) check("held_start_timeout", 32'(done_tick), 32'd1);
      t[k] = cyc;
    end
    start = 1'b0;
    check("held_period_1", 32'(t[1] - t[0]), 32'd18);
    check("held_period_2", 32'(t[2] - t[1]), 32'd18);
    last_bin = 14'd777; last_err = 1'b0;
    @(posedge clk); #1;

    // Reset five cycles into OP aborts without a done_tick.
    wait_ready();
    bcd = 16'h0123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_bin", 32'(bin), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    last_bin = '0; last_err = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    run_conv(16'h0042, 14'd42, 1'b0, 17, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
